// File: rtl/booth_mult_controller_pkg.sv
// ============================================================================
// booth_ctrl_pkg : shared state encoding and default sizing for the Booth
//                  multiplier controller.  Rev 1.0
// ============================================================================
`default_nettype none

package booth_ctrl_pkg;

   localparam int N_DEF  = 10;
   localparam int CW_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_EXAM  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/booth_mult_controller_if.sv
// ============================================================================
// booth_mult_controller_if : handshake and datapath strobe bundle between the
//                            Booth controller and its datapath/top level.  Rev 1.0
// ============================================================================
`default_nettype none

interface booth_mult_controller_if #(
   parameter int CW = 4
) ();

   logic          start;
   logic          q0;
   logic          qm1;
   logic          ready;
   logic          done;
   logic          ld_m;
   logic          ld_q;
   logic          sclr_acc;
   logic          sclr_qm1;
   logic          ld_acc;
   logic          sub;
   logic          shift;
   logic [CW-1:0] iter;

   // master: the controller issuing strobes
   modport master (
      input  start, q0, qm1,
      output ready, done, ld_m, ld_q, sclr_acc, sclr_qm1, ld_acc, sub, shift, iter
   );

   // slave: the datapath/top level consuming strobes
   modport slave (
      output start, q0, qm1,
      input  ready, done, ld_m, ld_q, sclr_acc, sclr_qm1, ld_acc, sub, shift, iter
   );

endinterface

`default_nettype wire

// File: rtl/booth_iter_counter.sv
// ============================================================================
// booth_iter_counter : iteration counter that saturates at N-1 and flags it.
//                      Rev 1.0
// ============================================================================
`default_nettype none

module booth_iter_counter #(
   parameter int N  = 10,
   parameter int CW = 4
) (
   input  wire logic          clk,
   input  wire logic          clr,
   input  wire logic          sclr,
   input  wire logic          inc,
   output logic      [CW-1:0] count,
   output logic               tc
);

   logic [CW-1:0] count_q;

   assign tc    = (count_q == CW'(N - 1));
   assign count = count_q;

   // holding at the terminal count keeps iter meaningful through DONE
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_q <= '0;
      end else if (sclr) begin
         count_q <= '0;
      end else if (inc && !tc) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/booth_mult_controller.sv
// ============================================================================
// booth_mult_controller : FSM sequencing the radix-2 Booth multiplier
//                         datapath with a start/ready/done handshake.  Rev 1.0
// ============================================================================
`default_nettype none

module booth_mult_controller
   import booth_ctrl_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int CW = CW_DEF
) (
   input  wire logic               clk,
   input  wire logic               clr,
   booth_mult_controller_if.master bus
);

   state_t state_q;
   state_t state_d;

   logic w_ready, w_done, w_ld_m, w_ld_q, w_sclr_acc, w_sclr_qm1;
   logic w_ld_acc, w_sub, w_shift;
   logic w_cnt_sclr, w_cnt_inc, w_cnt_tc;

   booth_iter_counter #(
      .N  (N),
      .CW (CW)
   ) u_iter_counter (
      .clk   (clk),
      .clr   (clr),
      .sclr  (w_cnt_sclr),
      .inc   (w_cnt_inc),
      .count (bus.iter),
      .tc    (w_cnt_tc)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      w_ready    = 1'b0;
      w_done     = 1'b0;
      w_ld_m     = 1'b0;
      w_ld_q     = 1'b0;
      w_sclr_acc = 1'b0;
      w_sclr_qm1 = 1'b0;
      w_ld_acc   = 1'b0;
      w_sub      = 1'b0;
      w_shift    = 1'b0;
      w_cnt_sclr = 1'b0;
      w_cnt_inc  = 1'b0;
      case (state_q)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.start) state_d = S_INIT;
         end
         S_INIT: begin
            w_ld_m     = 1'b1;
            w_ld_q     = 1'b1;
            w_sclr_acc = 1'b1;
            w_sclr_qm1 = 1'b1;
            w_cnt_sclr = 1'b1;
            state_d    = S_EXAM;
         end
         S_EXAM: begin
            // 10 -> start of a run of ones (subtract), 01 -> end of run (add)
            case ({bus.q0, bus.qm1})
               2'b10: begin
                  w_ld_acc = 1'b1;
                  w_sub    = 1'b1;
               end
               2'b01: w_ld_acc = 1'b1;
               default: ;
            endcase
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            w_shift = 1'b1;
            if (w_cnt_tc) begin
               state_d = S_DONE;
            end else begin
               w_cnt_inc = 1'b1;
               state_d   = S_EXAM;
            end
         end
         S_DONE: begin
            w_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.ready    = w_ready;
   assign bus.done     = w_done;
   assign bus.ld_m     = w_ld_m;
   assign bus.ld_q     = w_ld_q;
   assign bus.sclr_acc = w_sclr_acc;
   assign bus.sclr_qm1 = w_sclr_qm1;
   assign bus.ld_acc   = w_ld_acc;
   assign bus.sub      = w_sub;
   assign bus.shift    = w_shift;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_controller.sv
// ============================================================================
// tb_booth_mult_controller : self-checking bench with a small Booth datapath
//                            and an arithmetic product reference.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_booth_mult_controller;

   localparam int N  = 10;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   booth_mult_controller_if #(.CW(CW)) bus ();

   booth_mult_controller #(.N(N), .CW(CW)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   // datapath: ACC carries one guard bit so ACC-M cannot overflow for M=-2^(N-1)
   logic [N-1:0] opa = '0, opb = '0, m_r = '0, q_r = '0;
   logic [N:0]   acc_r = '0;
   logic         qm1_r = 1'b0;
   logic         use_dp = 1'b1, fq0 = 1'b0, fqm1 = 1'b0;
   int           cyc = 0;

   assign bus.q0  = use_dp ? q_r[0] : fq0;
   assign bus.qm1 = use_dp ? qm1_r  : fqm1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.ld_m)     m_r   <= opa;
      if (bus.ld_q)     q_r   <= opb;
      if (bus.sclr_acc) acc_r <= '0;
      if (bus.sclr_qm1) qm1_r <= 1'b0;
      if (bus.ld_acc)   acc_r <= bus.sub ? acc_r - {m_r[N-1], m_r} : acc_r + {m_r[N-1], m_r};
      if (bus.shift) begin
         acc_r <= {acc_r[N], acc_r[N:1]};
         q_r   <= {acc_r[0], q_r[N-1:1]};
         qm1_r <= q_r[0];
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // {ready, done, ld_m, ld_q, sclr_acc, sclr_qm1, ld_acc, shift}
   function automatic logic [7:0] strobes();
      return {bus.ready, bus.done, bus.ld_m, bus.ld_q,
              bus.sclr_acc, bus.sclr_qm1, bus.ld_acc, bus.shift};
   endfunction

   localparam logic [7:0] E_IDLE = 8'b1000_0000;
   localparam logic [7:0] E_INIT = 8'b0011_1100;
   localparam logic [7:0] E_DONE = 8'b0100_0000;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operation from IDLE; expectations follow the cycle schedule
   // (INIT at 1, EXAM even / SHIFT odd in 2..2N+1, DONE at 2N+2).
   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit dp,
                        input bit q0v, input bit qm1v, input string tag, output int n_ldacc);
      int         n_shift;
      int         p;
      logic [7:0] e;
      n_ldacc = 0;
      n_shift = 0;
      opa = a; opb = b; use_dp = dp; fq0 = q0v; fqm1 = qm1v;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 2*N+2; k++) begin
         e = '0;
         if (k == 1)            e = E_INIT;
         else if (k == 2*N+2)   e = E_DONE;
         else if (k % 2 == 0)   e[1] = bus.q0 ^ bus.qm1;
         else                   e[0] = 1'b1;
         chk($sformatf("%s strobes c%0d", tag, k), 32'(strobes()), 32'(e));
         if (e[1]) chk($sformatf("%s sub c%0d", tag, k), 32'(bus.sub), 32'(bus.q0 & ~bus.qm1));
         if (k >= 2)
            chk($sformatf("%s iter c%0d", tag, k), 32'(bus.iter),
                (k <= 2*N+1) ? 32'((k-2)/2) : 32'(N-1));
         if (k == 2*N+2 && dp) begin
            p = int'($signed(a)) * int'($signed(b));
            chk($sformatf("%s product", tag), 32'({acc_r[N-1:0], q_r}), 32'(p[2*N-1:0]));
         end
         n_ldacc += int'(bus.ld_acc);
         n_shift += int'(bus.shift);
         step();
      end
      chk($sformatf("%s back idle", tag), 32'(strobes()), 32'(E_IDLE));
      chk($sformatf("%s shift count", tag), 32'(n_shift), 32'(N));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            nla;
      int            t;
      int            d1;
      int            rdy;
      logic [N-1:0]  ra, rb;

      bus.start = 1'b0;
      #2 clr = 1'b0;
      #1;
      chk("rst strobes async", 32'(strobes()), 32'(E_IDLE));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst strobes", 32'(strobes()), 32'(E_IDLE));
         chk("rst iter", 32'(bus.iter), 32'd0);
      end
      @(negedge clk) clr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("post-rst idle", 32'(strobes()), 32'(E_IDLE));
      end

      do_op('0, '0, 1'b0, 1'b0, 1'b0, "null", nla);
      chk("null ld_acc count", 32'(nla), 32'd0);

      do_op('0, '0, 1'b0, 1'b1, 1'b0, "forcesub", nla);
      chk("forcesub ld_acc count", 32'(nla), 32'(N));

      do_op(10'h3FB, 10'h007, 1'b1, 1'b0, 1'b0, "m5x7", nla);
      do_op(10'h200, 10'h200, 1'b1, 1'b0, 1'b0, "minxmin", nla);

      for (int r = 0; r < 4; r++) begin
         ra = 10'($urandom_range(1023, 0));
         rb = 10'($urandom_range(1023, 0));
         do_op(ra, rb, 1'b1, 1'b0, 1'b0, $sformatf("rand%0d", r), nla);
      end

      // back-to-back with start held high
      use_dp = 1'b1;
      bus.start = 1'b1;
      t = 0;
      while (!bus.done && t < 40) begin step(); t++; end
      chk("b2b done1 seen", 32'(bus.done), 32'd1);
      d1 = cyc;
      rdy = 0;
      step();
      t = 0;
      while (!bus.done && t < 40) begin rdy += int'(bus.ready); step(); t++; end
      chk("b2b done2 seen", 32'(bus.done), 32'd1);
      bus.start = 1'b0;
      chk("b2b spacing", 32'(cyc - d1), 32'd23);
      chk("b2b ready cycles", 32'(rdy), 32'd1);
      step();
      chk("b2b idle after", 32'(strobes()), 32'(E_IDLE));

      // reset asserted during the SHIFT with iter=4
      opa = 10'h3FB; opb = 10'h007;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      t = 0;
      while (!(bus.shift && bus.iter == 4'd4) && t < 40) begin step(); t++; end
      chk("midrst reached shift4", 32'(bus.shift && bus.iter == 4'd4), 32'd1);
      clr = 1'b0;
      #1;
      chk("midrst async strobes", 32'(strobes()), 32'(E_IDLE));
      chk("midrst async iter", 32'(bus.iter), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst hold strobes", 32'(strobes()), 32'(E_IDLE));
         chk("midrst hold iter", 32'(bus.iter), 32'd0);
      end
      @(negedge clk) clr = 1'b1;
      step();
      chk("midrst release idle", 32'(strobes()), 32'(E_IDLE));
      do_op(10'h3FB, 10'h007, 1'b1, 1'b0, 1'b0, "after-rst", nla);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/booth_mult_controller.md
Name: booth_mult_controller

Overview:
- FSM that sequences the 10-bit register datapath of the CA1 radix-2 Booth signed multiplier.
- The datapath holds multiplicand M, accumulator ACC, multiplier Q and bit Q(-1), each built from loadable, sync-clearable registers.
- This block issues the load, clear, add/sub and shift strobes, counts iterations, and runs a start/ready/done handshake with the top level.
- Pure controller: no data bits pass through it except the two Booth decision bits.

Parameters:
- N, 10, operand width and number of Booth iterations (N >= 2).
- CW, 4, iteration counter width; must satisfy 2^CW > N-1.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset; 0 = reset, 1 = run.
- start  input  1  level request; sampled only in IDLE.
- q0  input  1  LSB of the Q register.
- qm1  input  1  Q(-1) register bit.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the product is valid.
- ld_m  output  1  load M from operand bus.
- ld_q  output  1  load Q from operand bus.
- sclr_acc  output  1  synchronous clear of ACC.
- sclr_qm1  output  1  synchronous clear of Q(-1).
- ld_acc  output  1  load ACC with the adder/subtractor result.
- sub  output  1  adder mode; 1 = ACC-M, 0 = ACC+M. Meaningful only with ld_acc.
- shift  output  1  arithmetic right shift of {ACC,Q,Q(-1)}.
- iter  output  CW  current iteration index, for debug.

Behaviour:
- States:
  - IDLE: ready=1. If start=1 go to INIT, else stay.
  - INIT: assert ld_m, ld_q, sclr_acc, sclr_qm1. Clear the counter. Always go to EXAM.
  - EXAM: decode {q0,qm1}.
    - 10: ld_acc=1, sub=1.
    - 01: ld_acc=1, sub=0.
    - 00 or 11: no strobe.
    - Always go to SHIFT.
  - SHIFT: shift=1.
    - If iter == N-1, go to DONE and hold the counter.
    - Else increment iter and go to EXAM.
  - DONE: done=1. Go to IDLE.
- Output style: all strobes are combinational from state. In EXAM they also depend on q0/qm1 (Mealy), and the datapath samples them at the next rising edge.
- Only one strobe group is active per cycle. ld_acc and shift are never high together.
- Latency: start is sampled high at edge 0. Then INIT is cycle 1, EXAM/SHIFT pairs are cycles 2..2N+1, and done=1 in cycle 2N+2. For N=10, done is high exactly 22 cycles after the sampling edge.
- Throughput: with start held high, DONE→IDLE→INIT runs back-to-back, giving a new operation every 2N+3 cycles.
- start is ignored outside IDLE. Operands must stay stable on the bus during INIT.
- Reset (clr=0) at any time, including mid-iteration:
  - state=IDLE, iter=0.
  - All strobes and done are 0; ready=1.
  - This takes effect asynchronously; release is synchronous to clk.
- Unused state encodings recover to IDLE on the next edge.
- Counter does not wrap: it saturates at N-1 until INIT clears it.

Decomposition:
- Package booth_ctrl_pkg holds:
  - state encoding constants S_IDLE, S_INIT, S_EXAM, S_SHIFT, S_DONE (3-bit binary);
  - the default N/CW values.
- One natural sub-module: booth_iter_counter, a CW-bit counter with inputs clk, clr (active-low async), sclr, inc and output tc (count == N-1).
- The FSM lives in the top module.

Test Plan:
- Reset check: drive clr=0 mid-run, then hold 3 cycles.
  - Expect ready=1, done=0, all strobes 0, iter=0.
  - After clr=1 with start=0, the block stays IDLE.
- Null Booth pattern: pulse start with q0=qm1=0 held.
  - Expect INIT in cycle 1, then exactly 10 shift pulses on alternating cycles.
  - Expect ld_acc never asserted and done=1 only in cycle 22.
- Forced subtract pattern: hold q0=1, qm1=0.
  - Expect ld_acc=1 with sub=1 in every EXAM, 10 times total.
  - Expect shift=1 in every SHIFT, with no overlap between ld_acc and shift.
- Full datapath integration (bench instantiates four registers plus adder):
  - M = 10'h3FB (-5), Q = 10'h007 (7).
  - On done, {ACC,Q} must equal 20'hFFFDD (-35).
  - Also check M = 10'h200 × Q = 10'h200 → 20'h40000.
- Back-to-back: hold start=1 across two operations.
  - Expect done pulses exactly 23 cycles apart.
  - Expect ready high for one cycle between them.
- Reset mid-operation: assert clr=0 during the SHIFT with iter=4.
  - Expect immediate IDLE and iter=0.
  - A following start gives correct -5×7 with done 22 cycles later.
